// File: rtl/tx_channel_arbiter.sv
// tx_channel_arbiter
//   Packet-level weighted round-robin scheduler that merges the write stream
//   (AW header plus W beats) and the read-request stream (AR, single beat)
//   onto one shared 128-bit transmit stream toward the network layer.
//   A grant is held for a whole packet, up to and including the last beat.
//   Under contention, AW gets at most AW_WEIGHT consecutive packets while AR
//   waits, and AR gets at most AR_WEIGHT consecutive packets while AW waits.
//   A weight of 0 is not a legal setting.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   start_soft                 grant enable; low blocks new packets only
//   aw_channel*                write-stream beat, sideband, valid/ready
//   ar_channel*                read-stream beat, sideband, valid/ready
//   tx_data/keep/last          merged stream beat (one register slice)
//   tx_connection_id/byte_num  sideband of the current tx beat
//   tx_channel                 0 = write packet, 1 = read packet
//   tx_valid, tx_ready         merged stream handshake
//   aw_pkt_cnt, ar_pkt_cnt     packets forwarded per channel (wrapping)
//   busy                       high while a packet is open or tx_valid is high
module tx_channel_arbiter #(
   parameter int AW_WEIGHT = 4,
   parameter int AR_WEIGHT = 2,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_soft,

   input  logic [127:0]     aw_channel,
   input  logic [15:0]      aw_channel_keep,
   input  logic             aw_channel_last,
   input  logic [3:0]       aw_channel_connection_id,
   input  logic [12:0]      aw_channel_byte_num,
   input  logic             aw_channel_valid,
   output logic             aw_channel_ready,

   input  logic [127:0]     ar_channel,
   input  logic [15:0]      ar_channel_keep,
   input  logic             ar_channel_last,
   input  logic [3:0]       ar_channel_connection_id,
   input  logic [12:0]      ar_channel_byte_num,
   input  logic             ar_channel_valid,
   output logic             ar_channel_ready,

   output logic [127:0]     tx_data,
   output logic [15:0]      tx_keep,
   output logic             tx_last,
   output logic [3:0]       tx_connection_id,
   output logic [12:0]      tx_byte_num,
   output logic             tx_channel,
   output logic             tx_valid,
   input  logic             tx_ready,

   output logic [CNT_W-1:0] aw_pkt_cnt,
   output logic [CNT_W-1:0] ar_pkt_cnt,
   output logic             busy
);

   localparam int MAX_W = (AW_WEIGHT > AR_WEIGHT) ? AW_WEIGHT : AR_WEIGHT;
   localparam int RUN_W = $clog2(MAX_W + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      AW_PKT = 2'd1,
      AR_PKT = 2'd2
   } state_t;

   state_t           state, state_next;

   // prio / last_ch: 0 = AW, 1 = AR
   logic             prio;
   logic             last_ch;
   logic [RUN_W-1:0] run;

   logic             slot_free;
   logic             grant_aw, grant_ar;
   logic             aw_acc, ar_acc;
   logic             pkt_done;
   logic [RUN_W-1:0] run_inc;
   logic [RUN_W-1:0] done_weight;

   assign slot_free        = ~tx_valid | tx_ready;
   assign aw_channel_ready = grant_aw & slot_free;
   assign ar_channel_ready = grant_ar & slot_free;
   assign busy             = (state != IDLE) | tx_valid;

   // In IDLE the grant is decided from the current valids so the first beat
   // moves in the same cycle as the decision; inside a packet the owning
   // channel keeps the grant regardless of start_soft.
   always_comb begin
      state_next = state;
      grant_aw   = 1'b0;
      grant_ar   = 1'b0;
      aw_acc     = 1'b0;
      ar_acc     = 1'b0;
      case (state)
         IDLE: begin
            if (start_soft) begin
               if (aw_channel_valid && (!ar_channel_valid || !prio))
                  grant_aw = 1'b1;
               else if (ar_channel_valid)
                  grant_ar = 1'b1;
            end
            aw_acc = grant_aw & slot_free & aw_channel_valid;
            ar_acc = grant_ar & slot_free & ar_channel_valid;
            if (aw_acc && !aw_channel_last)
               state_next = AW_PKT;
            else if (ar_acc && !ar_channel_last)
               state_next = AR_PKT;
         end
         AW_PKT: begin
            grant_aw = 1'b1;
            aw_acc   = slot_free & aw_channel_valid;
            if (aw_acc && aw_channel_last)
               state_next = IDLE;
         end
         AR_PKT: begin
            grant_ar = 1'b1;
            ar_acc   = slot_free & ar_channel_valid;
            if (ar_acc && ar_channel_last)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Weight bookkeeping for the packet completing this cycle.
   always_comb begin
      pkt_done    = (aw_acc & aw_channel_last) | (ar_acc & ar_channel_last);
      run_inc     = (ar_acc == last_ch) ? run + RUN_W'(1) : RUN_W'(1);
      done_weight = ar_acc ? RUN_W'(AR_WEIGHT) : RUN_W'(AW_WEIGHT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio    <= 1'b0;
         last_ch <= 1'b0;
         run     <= '0;
      end else if (pkt_done) begin
         last_ch <= ar_acc;
         if (run_inc == done_weight) begin
            prio <= ~ar_acc;
            run  <= '0;
         end else begin
            prio <= ar_acc;
            run  <= run_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data          <= '0;
         tx_keep          <= '0;
         tx_last          <= 1'b0;
         tx_connection_id <= '0;
         tx_byte_num      <= '0;
         tx_channel       <= 1'b0;
         tx_valid         <= 1'b0;
      end else if (aw_acc) begin
         tx_data          <= aw_channel;
         tx_keep          <= aw_channel_keep;
         tx_last          <= aw_channel_last;
         tx_connection_id <= aw_channel_connection_id;
         tx_byte_num      <= aw_channel_byte_num;
         tx_channel       <= 1'b0;
         tx_valid         <= 1'b1;
      end else if (ar_acc) begin
         tx_data          <= ar_channel;
         tx_keep          <= ar_channel_keep;
         tx_last          <= ar_channel_last;
         tx_connection_id <= ar_channel_connection_id;
         tx_byte_num      <= ar_channel_byte_num;
         tx_channel       <= 1'b1;
         tx_valid         <= 1'b1;
      end else if (tx_ready) begin
         tx_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aw_pkt_cnt <= '0;
         ar_pkt_cnt <= '0;
      end else begin
         if (aw_acc && aw_channel_last)
            aw_pkt_cnt <= aw_pkt_cnt + CNT_W'(1);
         if (ar_acc && ar_channel_last)
            ar_pkt_cnt <= ar_pkt_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_tx_channel_arbiter.sv
// Directed bench for tx_channel_arbiter: a per-cycle vector table covering
// single AR beats, AW packets with a competing AR, tx_ready back-pressure and
// start_soft gating, followed by hand-written reset and saturation sequences.
module tb_tx_channel_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic          start_soft;
   logic [127:0]  aw_channel;
   logic [15:0]   aw_channel_keep;
   logic          aw_channel_last;
   logic [3:0]    aw_channel_connection_id;
   logic [12:0]   aw_channel_byte_num;
   logic          aw_channel_valid;
   logic          aw_channel_ready;
   logic [127:0]  ar_channel;
   logic [15:0]   ar_channel_keep;
   logic          ar_channel_last;
   logic [3:0]    ar_channel_connection_id;
   logic [12:0]   ar_channel_byte_num;
   logic          ar_channel_valid;
   logic          ar_channel_ready;
   logic [127:0]  tx_data;
   logic [15:0]   tx_keep;
   logic          tx_last;
   logic [3:0]    tx_connection_id;
   logic [12:0]   tx_byte_num;
   logic          tx_channel;
   logic          tx_valid;
   logic          tx_ready;
   logic [31:0]   aw_pkt_cnt;
   logic [31:0]   ar_pkt_cnt;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tx_channel_arbiter #(.AW_WEIGHT(4), .AR_WEIGHT(2), .CNT_W(32)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .start_soft               (start_soft),
      .aw_channel               (aw_channel),
      .aw_channel_keep          (aw_channel_keep),
      .aw_channel_last          (aw_channel_last),
      .aw_channel_connection_id (aw_channel_connection_id),
      .aw_channel_byte_num      (aw_channel_byte_num),
      .aw_channel_valid         (aw_channel_valid),
      .aw_channel_ready         (aw_channel_ready),
      .ar_channel               (ar_channel),
      .ar_channel_keep          (ar_channel_keep),
      .ar_channel_last          (ar_channel_last),
      .ar_channel_connection_id (ar_channel_connection_id),
      .ar_channel_byte_num      (ar_channel_byte_num),
      .ar_channel_valid         (ar_channel_valid),
      .ar_channel_ready         (ar_channel_ready),
      .tx_data                  (tx_data),
      .tx_keep                  (tx_keep),
      .tx_last                  (tx_last),
      .tx_connection_id         (tx_connection_id),
      .tx_byte_num              (tx_byte_num),
      .tx_channel               (tx_channel),
      .tx_valid                 (tx_valid),
      .tx_ready                 (tx_ready),
      .aw_pkt_cnt               (aw_pkt_cnt),
      .ar_pkt_cnt               (ar_pkt_cnt),
      .busy                     (busy)
   );

   // One cycle of stimulus plus expected readies (before the edge) and
   // expected registered outputs (after the edge).
   typedef struct {
      int ss, awv, awl, awd, arv, arl, ard, rdy;
      int e_awr, e_arr, e_tv, e_tch, e_tl, e_td, e_busy, e_awc, e_arc;
   } vec_t;

   vec_t vec [25];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int ss, input int awv, input int awl, input int awd,
                        input int arv, input int arl, input int ard, input int rdy);
      start_soft       = ss[0];
      aw_channel_valid = awv[0];
      aw_channel_last  = awl[0];
      aw_channel       = {16{awd[7:0]}};
      ar_channel_valid = arv[0];
      ar_channel_last  = arl[0];
      ar_channel       = {16{ard[7:0]}};
      tx_ready         = rdy[0];
   endtask

   task automatic chk_beat(input string nm, input int ch, input int lst, input int d);
      logic [7:0] db;
      db = d[7:0];
      chk({nm, ".tx_channel"}, 128'(tx_channel), 128'(ch));
      chk({nm, ".tx_last"}, 128'(tx_last), 128'(lst));
      chk({nm, ".tx_data"}, tx_data, {16{db}});
      chk({nm, ".tx_keep"}, 128'(tx_keep), (ch != 0) ? 128'h00FF : 128'hFFFF);
      chk({nm, ".tx_conn"}, 128'(tx_connection_id), (ch != 0) ? 128'd3 : 128'd5);
      chk({nm, ".tx_bytes"}, 128'(tx_byte_num), (ch != 0) ? 128'h00B : 128'h040);
   endtask

   initial begin
      //          ss awv awl awd    arv arl ard    rdy  awr arr tv tch tl td     busy awc arc
      vec[0]  = '{1, 0, 0, 0,     1, 1, 'hB1, 1,   0, 1,  1, 1, 1, 'hB1, 1,   0, 1};
      vec[1]  = '{1, 0, 0, 0,     0, 0, 0,    1,   0, 0,  0, 0, 0, 0,    0,   0, 1};
      vec[2]  = '{1, 1, 0, 'hA1,  0, 0, 0,    1,   1, 0,  1, 0, 0, 'hA1, 1,   0, 1};
      vec[3]  = '{1, 1, 0, 'hA2,  1, 1, 'hB2, 1,   1, 0,  1, 0, 0, 'hA2, 1,   0, 1};
      vec[4]  = '{1, 1, 0, 'hA3,  1, 1, 'hB2, 1,   1, 0,  1, 0, 0, 'hA3, 1,   0, 1};
      vec[5]  = '{1, 1, 0, 'hA4,  1, 1, 'hB2, 1,   1, 0,  1, 0, 0, 'hA4, 1,   0, 1};
      vec[6]  = '{1, 1, 1, 'hA5,  1, 1, 'hB2, 1,   1, 0,  1, 0, 1, 'hA5, 1,   1, 1};
      vec[7]  = '{1, 0, 0, 0,     1, 1, 'hB2, 1,   0, 1,  1, 1, 1, 'hB2, 1,   1, 2};
      vec[8]  = '{1, 0, 0, 0,     0, 0, 0,    1,   0, 0,  0, 0, 0, 0,    0,   1, 2};
      vec[9]  = '{1, 1, 0, 'hC1,  0, 0, 0,    1,   1, 0,  1, 0, 0, 'hC1, 1,   1, 2};
      vec[10] = '{1, 1, 0, 'hC2,  0, 0, 0,    0,   0, 0,  1, 0, 0, 'hC1, 1,   1, 2};
      vec[11] = '{1, 1, 0, 'hC2,  0, 0, 0,    1,   1, 0,  1, 0, 0, 'hC2, 1,   1, 2};
      vec[12] = '{1, 1, 0, 'hC3,  0, 0, 0,    0,   0, 0,  1, 0, 0, 'hC2, 1,   1, 2};
      vec[13] = '{1, 1, 0, 'hC3,  0, 0, 0,    1,   1, 0,  1, 0, 0, 'hC3, 1,   1, 2};
      vec[14] = '{1, 1, 1, 'hC4,  0, 0, 0,    0,   0, 0,  1, 0, 0, 'hC3, 1,   1, 2};
      vec[15] = '{1, 1, 1, 'hC4,  0, 0, 0,    1,   1, 0,  1, 0, 1, 'hC4, 1,   2, 2};
      vec[16] = '{1, 0, 0, 0,     0, 0, 0,    1,   0, 0,  0, 0, 0, 0,    0,   2, 2};
      vec[17] = '{1, 1, 0, 'hD1,  1, 1, 'hB3, 1,   1, 0,  1, 0, 0, 'hD1, 1,   2, 2};
      vec[18] = '{0, 1, 0, 'hD2,  1, 1, 'hB3, 1,   1, 0,  1, 0, 0, 'hD2, 1,   2, 2};
      vec[19] = '{0, 1, 0, 'hD3,  1, 1, 'hB3, 1,   1, 0,  1, 0, 0, 'hD3, 1,   2, 2};
      vec[20] = '{0, 1, 1, 'hD4,  1, 1, 'hB3, 1,   1, 0,  1, 0, 1, 'hD4, 1,   3, 2};
      vec[21] = '{0, 0, 0, 0,     1, 1, 'hB3, 1,   0, 0,  0, 0, 0, 0,    0,   3, 2};
      vec[22] = '{0, 0, 0, 0,     1, 1, 'hB3, 1,   0, 0,  0, 0, 0, 0,    0,   3, 2};
      vec[23] = '{1, 0, 0, 0,     1, 1, 'hB3, 1,   0, 1,  1, 1, 1, 'hB3, 1,   3, 3};
      vec[24] = '{1, 0, 0, 0,     0, 0, 0,    1,   0, 0,  0, 0, 0, 0,    0,   3, 3};

      aw_channel_keep          = 16'hFFFF;
      aw_channel_connection_id = 4'd5;
      aw_channel_byte_num      = 13'h040;
      ar_channel_keep          = 16'h00FF;
      ar_channel_connection_id = 4'd3;
      ar_channel_byte_num      = 13'h00B;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #12;
      chk("rst.tx_valid", 128'(tx_valid), 128'd0);
      chk("rst.busy", 128'(busy), 128'd0);
      chk("rst.aw_cnt", 128'(aw_pkt_cnt), 128'd0);
      chk("rst.ar_cnt", 128'(ar_pkt_cnt), 128'd0);
      chk("rst.tx_data", tx_data, 128'd0);
      chk("rst.aw_ready", 128'(aw_channel_ready), 128'd0);
      chk("rst.ar_ready", 128'(ar_channel_ready), 128'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         drive(vec[i].ss, vec[i].awv, vec[i].awl, vec[i].awd,
               vec[i].arv, vec[i].arl, vec[i].ard, vec[i].rdy);
         #1;
         chk($sformatf("v%0d.aw_ready", i), 128'(aw_channel_ready), 128'(vec[i].e_awr));
         chk($sformatf("v%0d.ar_ready", i), 128'(ar_channel_ready), 128'(vec[i].e_arr));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d.tx_valid", i), 128'(tx_valid), 128'(vec[i].e_tv));
         chk($sformatf("v%0d.busy", i), 128'(busy), 128'(vec[i].e_busy));
         chk($sformatf("v%0d.aw_cnt", i), 128'(aw_pkt_cnt), 128'(vec[i].e_awc));
         chk($sformatf("v%0d.ar_cnt", i), 128'(ar_pkt_cnt), 128'(vec[i].e_arc));
         if (vec[i].e_tv != 0)
            chk_beat($sformatf("v%0d", i), vec[i].e_tch, vec[i].e_tl, vec[i].e_td);
      end

      // Reset in the middle of an AW packet, then an AR packet from reset.
      @(negedge clk);
      drive(1, 1, 0, 'hE1, 0, 0, 0, 1);
      @(negedge clk);
      drive(1, 1, 0, 'hE2, 0, 0, 0, 1);
      @(negedge clk);
      chk("mid.busy_before", 128'(busy), 128'd1);
      reset = 1'b1;
      #1;
      chk("mid.tx_valid", 128'(tx_valid), 128'd0);
      chk("mid.busy", 128'(busy), 128'd0);
      chk("mid.aw_cnt", 128'(aw_pkt_cnt), 128'd0);
      chk("mid.ar_cnt", 128'(ar_pkt_cnt), 128'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(1, 0, 0, 0, 1, 1, 'hB4, 1);
      #1;
      chk("post.ar_ready", 128'(ar_channel_ready), 128'd1);
      chk("post.aw_ready", 128'(aw_channel_ready), 128'd0);
      @(posedge clk);
      #1;
      chk("post.tx_valid", 128'(tx_valid), 128'd1);
      chk_beat("post", 1, 1, 'hB4);
      chk("post.ar_cnt", 128'(ar_pkt_cnt), 128'd1);
      chk("post.aw_cnt", 128'(aw_pkt_cnt), 128'd0);

      // Both channels saturated with 1-beat packets from a fresh reset:
      // AW,AW,AW,AW,AR,AR repeating.
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      drive(1, 1, 1, 'h5A, 1, 1, 'hB5, 1);
      for (int p = 0; p < 60; p++) begin
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d.tx_valid", p), 128'(tx_valid), 128'd1);
         chk($sformatf("sat%0d.tx_channel", p), 128'(tx_channel), ((p % 6) >= 4) ? 128'd1 : 128'd0);
      end
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      chk("sat.aw_cnt", 128'(aw_pkt_cnt), 128'd40);
      chk("sat.ar_cnt", 128'(ar_pkt_cnt), 128'd20);
      @(posedge clk);
      #1;
      chk("sat.drain_valid", 128'(tx_valid), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
